// File: rtl/psr2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psr2_pkg
//  Description : Shared constants for the psr2 serial family. Holds the
//                deframer state encoding, the default payload width and a
//                helper that sizes the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package psr2_pkg;

  // Default payload width, shared with psr2 and the splitter
  localparam int PSR2_WIDTH = 8;

  // Deframer state encoding
  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;

  // Counter must reach WIDTH itself without wrapping, hence the extra bit
  function automatic int psr2_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : psr2_pkg
`default_nettype wire

// File: rtl/psr2_hold.sv
`default_nettype none
// ============================================================================
//  Module      : psr2_hold
//  Description : One-deep valid/ready output register. A load is taken when
//                the register is empty or is being drained on the same clock,
//                so back-to-back words never see a bubble. A load that finds
//                the register full and not draining is dropped and reported
//                with a one-cycle full_drop pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module psr2_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             full_drop
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             vld_q;
  logic             vld_d;
  logic             drop_q;
  logic             drop_d;
  logic             w_take;

  // A load is accepted when there is room now or the held word leaves this clock
  assign w_take = load && (!vld_q || rdy);

  // Next-state for the holding register, valid flag and drop pulse
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    drop_d = 1'b0;
    if (w_take) begin
      data_d = load_data;
      vld_d  = 1'b1;
    end else if (load) begin
      // Full and not draining: keep the held word, report the loss
      drop_d = 1'b1;
    end else if (vld_q && rdy) begin
      vld_d  = 1'b0;
    end
  end

  // Register update with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  assign data      = data_q;
  assign vld       = vld_q;
  assign full_drop = drop_q;

endmodule : psr2_hold
`default_nettype wire

// File: rtl/psr2_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : psr2_deframer
//  Description : Recovers WIDTH-bit words from the qualified psr2 serial
//                stream. Hunts for a start bit, shifts in the payload, checks
//                the stop bit and hands good words to a one-deep valid/ready
//                output register. Framing errors and dropped words are flagged
//                with registered one-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module psr2_deframer
  import psr2_pkg::*;
#(
  parameter int WIDTH     = PSR2_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit START_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_vld,
  input  logic             pout_rdy,
  output logic             frm_err,
  output logic             ovf
);

  localparam int                 c_CNT_W = psr2_cnt_w(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam bit                 c_STOP_BIT = ~START_BIT;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   shift_d;
  logic               frm_err_q;
  logic               frm_err_d;
  logic [WIDTH-1:0]   w_shift_in;
  logic               w_word_good;

  // Bit ordering of the shift register is fixed at elaboration
  if (MSB_FIRST) begin : g_msb_first
    assign w_shift_in = {shift_q[WIDTH-2:0], sin};
  end else begin : g_lsb_first
    assign w_shift_in = {sin, shift_q[WIDTH-1:1]};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: moves only on qualified samples, so gaps simply stall it
  always_comb begin
    state_d = state_q;
    if (sin_vld) begin
      case (state_q)
        HUNT:    if (sin == START_BIT) state_d = SHIFT;
        SHIFT:   if (cnt_q == c_LAST)  state_d = STOP;
        STOP:    state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM outputs: stop-bit verdict, either a good word or a framing error
  always_comb begin
    w_word_good = 1'b0;
    frm_err_d   = 1'b0;
    if (sin_vld && (state_q == STOP)) begin
      if (sin == c_STOP_BIT) begin
        w_word_good = 1'b1;
      end else begin
        frm_err_d   = 1'b1;
      end
    end
  end

  // Counter and shift register next-state; both frozen while sin_vld is low
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (sin_vld) begin
      if ((state_q == HUNT) && (sin == START_BIT)) begin
        cnt_d = '0;
      end else if (state_q == SHIFT) begin
        // Reaches WIDTH on the last payload bit and is cleared by the next start
        cnt_d   = cnt_q + c_ONE;
        shift_d = w_shift_in;
      end
    end
  end

  // Datapath and error-pulse registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      frm_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign frm_err = frm_err_q;

  // Output register; its drop pulse is the overflow flag
  psr2_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .clr       (clr),
    .load      (w_word_good),
    .load_data (shift_q),
    .rdy       (pout_rdy),
    .data      (pout_data),
    .vld       (pout_vld),
    .full_drop (ovf)
  );

endmodule : psr2_deframer
`default_nettype wire
